seg_display_reader: RTL and testbench
=====================================

// Module: seg_display_reader
// PURPOSE
//  Reads data out of the basic computer and shows it on the board's four multiplexed 7-segment digits.
//  It is the read-side counterpart of the switch-nibble program loader.
//  mode=0: shows the live accumulator as 4 hex digits.
//  mode=1: dumps program/data memory word by word through a registered read port, stepped by button or auto-scan.
// PARAMETERS
//  ADDR_W       5      memory address width
//  MEM_DEPTH    21     words in memory; valid addresses 0..MEM_DEPTH-1
//  REFRESH_DIV  50000  clk cycles each digit stays lit
//  SCAN_DIV     25e6   clk cycles spent in HOLD before auto-advance
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  mode       in   1       0 = live AC, 1 = memory dump
//  ac         in   16      accumulator value
//  step       in   1       level button, already synchronised; rising edge advances address
//  auto_scan  in   1       1 = advance every SCAN_DIV HOLD cycles
//  mem_addr   out  ADDR_W  memory read address
//  mem_rd     out  1       read strobe; mem_data is valid the following cycle
//  mem_data   in   16      memory read data
//  addr_disp  out  ADDR_W  address currently displayed (LEDs)
//  busy       out  1       1 while in FETCH or CAPTURE
//  seg        out  7       {g,f,e,d,c,b,a}, active-low
//  an         out  4       digit enables, active-low; an[0] = least significant nibble
// BEHAVIOUR
//  Reset (async): seg=7'h7F, an=4'hF, mem_rd=0, mem_addr=0, addr_disp=0, busy=0.
//   Also clears state=IDLE, disp_word=0, digit index=0, all counters=0.
//  Refresh:
//   - ref_cnt counts 0..REFRESH_DIV-1. On terminal count the digit index advances 0->1->2->3->0.
//   - an/seg are registered and update on that tick.
//   - Digit i shows disp_word[4i+3:4i] through the hex decoder (0-F).
//  mode=0 (state IDLE): disp_word <= ac every cycle; mem_rd=0.
//  FSM states: IDLE, FETCH, CAPTURE, HOLD.
//   IDLE & mode=1 -> FETCH, cur_addr=0.
//   FETCH: mem_rd=1, mem_addr=cur_addr (registered, one cycle) -> CAPTURE.
//   CAPTURE: disp_word <= mem_data; addr_disp <= cur_addr -> HOLD; hold_cnt=0.
//   HOLD exits on either of:
//    - step rising edge (step & ~step_q);
//    - auto_scan=1 & hold_cnt==SCAN_DIV-1.
//   On exit: cur_addr <= (cur_addr==MEM_DEPTH-1) ? 0 : cur_addr+1 -> FETCH.
//   Any state with mode=0 -> IDLE next cycle; mem_rd drops that cycle and any in-flight read is discarded.
//  Latency: step edge sampled in HOLD at cycle n -> mem_rd=1 at n+1 -> disp_word valid at n+3.
//  Step edges arriving in FETCH or CAPTURE are dropped, not queued. step and auto in the same cycle give one advance.
//  Auto-scan period is SCAN_DIV+2 cycles per address.
//  Addresses never exceed MEM_DEPTH-1. Wrap is silent.
//  Async reset mid-fetch: outputs blank immediately; the read is abandoned.
//  No X filtering on ac or mem_data. Displayed value equals the input bits.
// STRUCTURE
//  Package bola_disp_pkg holds:
//   - state enum {IDLE, FETCH, CAPTURE, HOLD};
//   - SEG_BLANK = 7'h7F;
//   - AN_OFF = 4'hF.
//  Sub-module hex_to_7seg: combinational 4-bit to 7-bit active-low decoder.
//   0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, ... F->7'h0E.
//  Top holds the refresh counter, FSM, hold counter, step edge register and output registers.
// TESTING (REFRESH_DIV=4, SCAN_DIV=8, memory model with 1-cycle read, M[0]=16'h2003, M[1]=16'h1003, M[3]=16'h0001)
//  1. Reset, mode=0, ac=16'h1234:
//     an cycles 1110,1101,1011,0111 every 4 clks; seg = 7'h19, 7'h30, 7'h24, 7'h79.
//  2. mode 0->1:
//     next cycle mem_rd=1, mem_addr=0; two cycles later disp_word=16'h2003, addr_disp=0.
//     Step pulse -> mem_addr=1, disp_word=16'h1003.
//  3. Step at cur_addr=20 -> mem_rd with mem_addr=0; addr_disp returns to 0.
//  4. auto_scan=1, step=0: addr_disp steps 0,1,2,3 every 10 clks; disp_word at addr 3 = 16'h0001.
//  5. Step pulse during FETCH -> ignored, address advances once.
//     mode->0 during FETCH -> mem_rd=0 next cycle, disp_word follows ac.
//  6. rst_n low mid-CAPTURE -> seg=7'h7F, an=4'hF, busy=0 with no clock edge.
//     On release, mode=1 restarts at address 0.

Source files
------------

// File: rtl/bola_disp_pkg.sv
// ============================================================================
// bola_disp_pkg : shared types and constants for the 7-segment memory reader
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

package bola_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seg_display_reader_hex_to_7seg.sv
// ============================================================================
// hex_to_7seg : combinational nibble to active-low {g,f,e,d,c,b,a} decoder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module hex_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_reader.sv
// ============================================================================
// seg_display_reader : shows the live accumulator or a memory dump on four
//                      multiplexed 7-segment digits
// Revision 1.0       : initial release
// ============================================================================
`default_nettype none

module seg_display_reader
    import bola_disp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int MEM_DEPTH   = 21,
    parameter int REFRESH_DIV = 50000,
    parameter int SCAN_DIV    = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [15:0]       ac,
    input  logic              step,
    input  logic              auto_scan,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic [ADDR_W-1:0] addr_disp,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [3:0]        an
);

    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [REF_W-1:0]  c_REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

    state_t              r_state;
    logic [REF_W-1:0]    r_ref_cnt;
    logic [1:0]          r_digit;
    logic [15:0]         r_disp_word;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_step_q;

    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_next_addr;

    always_comb begin
        w_nibble = r_disp_word[3:0];
        case (r_digit)
            2'd0: w_nibble = r_disp_word[3:0];
            2'd1: w_nibble = r_disp_word[7:4];
            2'd2: w_nibble = r_disp_word[11:8];
            2'd3: w_nibble = r_disp_word[15:12];
            default: w_nibble = r_disp_word[3:0];
        endcase
    end

    hex_to_7seg u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // The digit lit on a tick is the current index; the index moves on afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_digit   <= 2'd0;
            seg       <= SEG_BLANK;
            an        <= AN_OFF;
        end else if (r_ref_cnt == c_REF_LAST) begin
            r_ref_cnt <= '0;
            r_digit   <= r_digit + 2'd1;
            seg       <= w_seg;
            an        <= ~(4'b0001 << r_digit);
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign w_advance   = (step & ~r_step_q) | (auto_scan & (r_hold_cnt == c_HOLD_LAST));
    assign w_next_addr = (r_cur_addr == c_ADDR_LAST) ? '0 : r_cur_addr + 1'b1;
    assign busy        = (r_state == FETCH) || (r_state == CAPTURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_disp_word <= 16'h0000;
            r_cur_addr  <= '0;
            r_hold_cnt  <= '0;
            r_step_q    <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            addr_disp   <= '0;
        end else begin
            r_step_q <= step;
            // Leaving dump mode abandons any outstanding read without capturing it.
            if (!mode) begin
                r_state <= IDLE;
                mem_rd  <= 1'b0;
                if (r_state == IDLE) begin
                    r_disp_word <= ac;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= FETCH;
                        r_cur_addr <= '0;
                        mem_addr   <= '0;
                        mem_rd     <= 1'b1;
                    end
                    FETCH: begin
                        mem_rd  <= 1'b0;
                        r_state <= CAPTURE;
                    end
                    CAPTURE: begin
                        r_disp_word <= mem_data;
                        addr_disp   <= r_cur_addr;
                        r_hold_cnt  <= '0;
                        r_state     <= HOLD;
                    end
                    HOLD: begin
                        if (w_advance) begin
                            r_cur_addr <= w_next_addr;
                            mem_addr   <= w_next_addr;
                            mem_rd     <= 1'b1;
                            r_state    <= FETCH;
                        end else if (r_hold_cnt == c_HOLD_LAST) begin
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        mem_rd  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_reader.sv
// ============================================================================
// tb_seg_display_reader : directed self-checking bench for seg_display_reader
// Revision 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_seg_display_reader;

    localparam int ADDR_W      = 5;
    localparam int MEM_DEPTH   = 21;
    localparam int REFRESH_DIV = 4;
    localparam int SCAN_DIV    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode = 1'b0;
    logic [15:0]       ac = 16'h0000;
    logic              step = 1'b0;
    logic              auto_scan = 1'b0;
    logic [15:0]       mem_data = 16'h0000;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] addr_disp;
    logic              busy;
    logic [6:0]        seg;
    logic [3:0]        an;

    logic [15:0]       mem [0:31];
    int                n_tests = 0;
    int                n_fail  = 0;

    seg_display_reader #(
        .ADDR_W      (ADDR_W),
        .MEM_DEPTH   (MEM_DEPTH),
        .REFRESH_DIV (REFRESH_DIV),
        .SCAN_DIV    (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .ac        (ac),
        .step      (step),
        .auto_scan (auto_scan),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .addr_disp (addr_disp),
        .busy      (busy),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp_an  [0:3];
        logic [6:0] exp_seg [0:3];
        exp_an[0] = 4'b1110; exp_seg[0] = 7'h19;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'h30;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'h24;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'h79;
        rst_n = 1'b0; mode = 1'b0; ac = 16'h1234;
        repeat (2) @(negedge clk);
        n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg); end
        n_tests++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected f", an); end
        n_tests++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_rd_busy: got %b%b expected 00", mem_rd, busy); end
        n_tests++; if (mem_addr !== 5'd0 || addr_disp !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", mem_addr, addr_disp); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (an !== 4'hF) begin n_fail++; $display("FAIL refresh_pre_tick_an: got %h expected f", an); end
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 4) @(negedge clk);
            n_tests++; if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                n_fail++; $display("FAIL refresh_digit%0d: got an=%b seg=%h expected an=%b seg=%h", d, an, seg, exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_dump_start();
        mode = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 5'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL dump_first_fetch: got rd=%b addr=%0d busy=%b expected 1/0/1", mem_rd, mem_addr, busy);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (dut.r_disp_word !== 16'h2003 || addr_disp !== 5'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL dump_word0: got %h @%0d busy=%b expected 2003 @0 busy=0", dut.r_disp_word, addr_disp, busy);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 5'd1) begin
            n_fail++; $display("FAIL step_fetch1: got rd=%b addr=%0d expected 1/1", mem_rd, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (dut.r_disp_word !== 16'h1003 || addr_disp !== 5'd1) begin
            n_fail++; $display("FAIL step_word1: got %h @%0d expected 1003 @1", dut.r_disp_word, addr_disp);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 19; i++) pulse_step();
        n_tests++; if (addr_disp !== 5'd20 || dut.r_disp_word !== 16'hA014) begin
            n_fail++; $display("FAIL wrap_last: got %h @%0d expected a014 @20", dut.r_disp_word, addr_disp);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
            n_fail++; $display("FAIL wrap_fetch: got rd=%b addr=%0d expected 1/0", mem_rd, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (addr_disp !== 5'd0 || dut.r_disp_word !== 16'h2003) begin
            n_fail++; $display("FAIL wrap_word0: got %h @%0d expected 2003 @0", dut.r_disp_word, addr_disp);
        end
    endtask

    task automatic test_auto_scan();
        auto_scan = 1'b1;
        for (int a = 1; a < 4; a++) begin
            repeat (9) @(negedge clk);
            n_tests++; if (addr_disp !== 5'(a - 1)) begin
                n_fail++; $display("FAIL auto_early%0d: got %0d expected %0d", a, addr_disp, a - 1);
            end
            @(negedge clk);
            n_tests++; if (addr_disp !== 5'(a)) begin
                n_fail++; $display("FAIL auto_step%0d: got %0d expected %0d", a, addr_disp, a);
            end
        end
        n_tests++; if (dut.r_disp_word !== 16'h0001) begin
            n_fail++; $display("FAIL auto_word3: got %h expected 0001", dut.r_disp_word);
        end
    endtask

    task automatic test_fetch_drop();
        repeat (8) @(negedge clk);
        n_tests++; if (busy !== 1'b1 || mem_addr !== 5'd4) begin
            n_fail++; $display("FAIL drop_in_fetch: got busy=%b addr=%0d expected 1/4", busy, mem_addr);
        end
        auto_scan = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        n_tests++; if (addr_disp !== 5'd4 || dut.r_disp_word !== 16'hA004) begin
            n_fail++; $display("FAIL drop_word4: got %h @%0d expected a004 @4", dut.r_disp_word, addr_disp);
        end
        repeat (6) @(negedge clk);
        n_tests++; if (addr_disp !== 5'd4 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL drop_no_advance: got addr=%0d busy=%b rd=%b expected 4/0/0", addr_disp, busy, mem_rd);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL abort_fetch_rd: got %b expected 1", mem_rd); end
        mode = 1'b0;
        ac   = 16'hBEEF;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_rd_drop: got rd=%b busy=%b expected 0/0", mem_rd, busy);
        end
        @(negedge clk);
        n_tests++; if (dut.r_disp_word !== 16'hBEEF || addr_disp !== 5'd4) begin
            n_fail++; $display("FAIL abort_follow_ac: got %h @%0d expected beef @4", dut.r_disp_word, addr_disp);
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_capture_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL async_blank: got seg=%h an=%h busy=%b rd=%b expected 7f/f/0/0", seg, an, busy, mem_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
            n_fail++; $display("FAIL restart_fetch: got rd=%b addr=%0d expected 1/0", mem_rd, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (dut.r_disp_word !== 16'h2003 || addr_disp !== 5'd0) begin
            n_fail++; $display("FAIL restart_word0: got %h @%0d expected 2003 @0", dut.r_disp_word, addr_disp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h2003;
        mem[1] = 16'h1003;
        mem[3] = 16'h0001;
        test_reset();
        test_dump_start();
        test_wrap();
        test_auto_scan();
        test_fetch_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
